// File: rtl/sub_serial.sv
// sub_serial: bit-serial ripple-borrow subtractor.
// Computes {borrow, diff} = a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell. A result takes W cycles.
//
// Optional feature macro: SUB_SERIAL_OVF_EN adds the signed-overflow output ovf.
//
// Ports:
//   clk    in   1  clock, rising edge
//   rst    in   1  synchronous active-high reset
//   start  in   1  request, sampled only while busy = 0
//   a      in   W  minuend, captured on accepted start
//   b      in   W  subtrahend, captured on accepted start
//   bin    in   1  borrow-in, captured on accepted start
//   busy   out  1  operation in progress
//   done   out  1  one-cycle pulse, diff/borrow newly valid
//   diff   out  W  a - b - bin mod 2^W
//   borrow out  1  borrow-out (a < b + bin, unsigned)
//   ovf    out  1  signed overflow (SUB_SERIAL_OVF_EN only)
module sub_serial #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] diff,
   output logic         borrow
`ifdef SUB_SERIAL_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state;
   logic [W-1:0]   a_reg;
   logic [W-1:0]   b_reg;
   // Holds the W-1 bits already produced; the newest bit enters at the top
   // and older bits drift toward bit 0, so the final bit completes the word.
   logic [W-2:0]   partial;
   logic           br;
   logic [CW-1:0]  cnt;

   logic           ai;
   logic           bi;
   logic           d;
   logic           br_next;
   logic [W-1:0]   word;

   // Full-subtractor cell for the current bit position.
   always_comb begin
      ai      = a_reg[cnt];
      bi      = b_reg[cnt];
      d       = ai ^ bi ^ br;
      br_next = (~ai & bi) | (~(ai ^ bi) & br);
      word    = {d, partial};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         a_reg   <= '0;
         b_reg   <= '0;
         partial <= '0;
         br      <= 1'b0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         diff    <= '0;
         borrow  <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg   <= a;
                  b_reg   <= b;
                  br      <= bin;
                  cnt     <= '0;
                  partial <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               if (cnt == LAST) begin
                  diff   <= word;
                  borrow <= br_next;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
`ifdef SUB_SERIAL_OVF_EN
                  // d is the result MSB at this point.
                  ovf    <= (a_reg[W-1] ^ b_reg[W-1]) & (a_reg[W-1] ^ d);
`endif
               end else begin
                  partial <= word[W-1:1];
                  br      <= br_next;
                  cnt     <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: self-checking bench for sub_serial (W = 8).
// Table-driven vectors plus hand-written sequences for start handling and
// mid-operation reset; a scoreboard queue holds expected results pushed at
// accept time and popped whenever done pulses.
// Define SUB_SERIAL_OVF_EN for both files to exercise the ovf output.
module tb_sub_serial;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
`ifdef SUB_SERIAL_OVF_EN
   logic         ovf;
`endif

   sub_serial #(.W(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .bin    (bin),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
`ifdef SUB_SERIAL_OVF_EN
      ,
      .ovf    (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      logic         br;
      logic         ov;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] d;
      logic         br;
      logic         ov;
   } vec_t;

   exp_t q[$];
   int   n_pass = 0;
   int   n_total = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endfunction

   // Reference model: 9-bit unsigned subtraction, MSB is the borrow.
   function automatic exp_t model(logic [W-1:0] ma, logic [W-1:0] mb, logic mbin);
      exp_t    e;
      logic [W:0] r;
      r    = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
      e.d  = r[W-1:0];
      e.br = r[W];
      e.ov = (ma[W-1] ^ mb[W-1]) & (ma[W-1] ^ r[W-1]);
      return e;
   endfunction

   // Scoreboard: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (done) begin
         if (q.size() == 0) begin
            chk("sb_unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_diff", 32'(diff), 32'(e.d));
            chk("sb_borrow", 32'(borrow), 32'(e.br));
`ifdef SUB_SERIAL_OVF_EN
            chk("sb_ovf", 32'(ovf), 32'(e.ov));
`endif
         end
      end
   end

   // Waits (bounded) for done; cyc = cycles since the accept edge, -1 on timeout.
   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 4 * W; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            cyc = i;
            return;
         end
      end
   endtask

   // Drives one operation from idle and checks its latency and pulse width.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
      int cyc;
      start = 1'b1;
      a     = ta;
      b     = tb;
      bin   = tbin;
      q.push_back(model(ta, tb, tbin));
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      chk("busy_after_accept", 32'(busy), 32'd1);
      wait_done(cyc);
      chk("done_latency", 32'(cyc), 32'(W));
      @(posedge clk);
      #1;
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("busy_after_done", 32'(busy), 32'd0);
   endtask

   vec_t vecs[8];

   initial begin
      int cyc;
      int n_done;

      vecs[0] = '{a: 8'd100, b: 8'd37,  bin: 1'b0, d: 8'd63,  br: 1'b0, ov: 1'b0};
      vecs[1] = '{a: 8'd0,   b: 8'd1,   bin: 1'b0, d: 8'd255, br: 1'b1, ov: 1'b0};
      vecs[2] = '{a: 8'd0,   b: 8'd0,   bin: 1'b1, d: 8'd255, br: 1'b1, ov: 1'b0};
      vecs[3] = '{a: 8'd200, b: 8'd200, bin: 1'b0, d: 8'd0,   br: 1'b0, ov: 1'b0};
      vecs[4] = '{a: 8'd255, b: 8'd0,   bin: 1'b1, d: 8'd254, br: 1'b0, ov: 1'b0};
      vecs[5] = '{a: 8'd0,   b: 8'd255, bin: 1'b1, d: 8'd0,   br: 1'b1, ov: 1'b0};
      vecs[6] = '{a: 8'd128, b: 8'd1,   bin: 1'b0, d: 8'd127, br: 1'b0, ov: 1'b1};
      vecs[7] = '{a: 8'd10,  b: 8'd3,   bin: 1'b0, d: 8'd7,   br: 1'b0, ov: 1'b0};

      // Reset held two cycles with start asserted.
      rst   = 1'b1;
      start = 1'b1;
      a     = 8'd77;
      b     = 8'd11;
      bin   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_borrow", 32'(borrow), 32'd0);
`ifdef SUB_SERIAL_OVF_EN
      chk("rst_ovf", 32'(ovf), 32'd0);
`endif
      start = 1'b0;
      rst   = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_no_start", 32'(busy), 32'd0);

      // Fixed vectors.
      foreach (vecs[i]) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].bin);
         chk("vec_diff", 32'(diff), 32'(vecs[i].d));
         chk("vec_borrow", 32'(borrow), 32'(vecs[i].br));
`ifdef SUB_SERIAL_OVF_EN
         chk("vec_ovf", 32'(ovf), 32'(vecs[i].ov));
`endif
      end

      // Start during RUN is ignored; start in the done cycle is accepted.
      start = 1'b1;
      a     = 8'd50;
      b     = 8'd10;
      bin   = 1'b0;
      q.push_back(model(8'd50, 8'd10, 1'b0));
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1;
      a     = 8'd5;
      b     = 8'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(cyc);
      chk("ignored_start_latency", 32'(cyc), 32'(W - 3));
      chk("ignored_diff", 32'(diff), 32'd40);
      chk("ignored_borrow", 32'(borrow), 32'd0);
      start = 1'b1;
      a     = 8'd7;
      b     = 8'd7;
      bin   = 1'b0;
      q.push_back(model(8'd7, 8'd7, 1'b0));
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      wait_done(cyc);
      chk("b2b_latency", 32'(cyc), 32'(W));
      chk("b2b_diff", 32'(diff), 32'd0);
      chk("b2b_borrow", 32'(borrow), 32'd0);
      @(posedge clk);
      #1;

      // Leave a nonzero result, then abort an operation with reset.
      do_op(8'd5, 8'd9, 1'b0);
      start = 1'b1;
      a     = 8'd250;
      b     = 8'd3;
      bin   = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_diff", 32'(diff), 32'd0);
      chk("abort_borrow", 32'(borrow), 32'd0);
      n_done = 0;
      for (int i = 0; i < 2 * W; i++) begin
         @(posedge clk);
         #1;
         if (done) n_done++;
      end
      chk("abort_no_done", 32'(n_done), 32'd0);
      do_op(8'd250, 8'd3, 1'b0);
      chk("after_abort_diff", 32'(diff), 32'd247);

      // Random operands, checked by the scoreboard.
      for (int i = 0; i < 16; i++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom));
      end

      chk("sb_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sub_serial.md
# sub_serial

Bit-serial ripple-borrow subtractor, the inverse operation of the registered 8-bit ripple-carry adder datapath. It accepts two W-bit operands and a borrow-in on a start pulse and evaluates one bit per clock through a single 1-bit full-subtractor cell, LSB first. It presents `{borrow, diff}` with a one-cycle `done` pulse. The block serves as the area-minimal subtract path alongside the adder in the arithmetic unit. It shares the adder's self-checking bench style.

## Interface
- `W`, default 8: operand and result width, W >= 2.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: request; sampled only when `busy` = 0.
- `a`  in  W: minuend, captured on accepted `start`.
- `b`  in  W: subtrahend, captured on accepted `start`.
- `bin`  in  1: borrow-in, captured on accepted `start`.
- `busy`  out  1: high while an operation is in progress.
- `done`  out  1: one-cycle pulse; `diff`/`borrow` newly valid.
- `diff`  out  W: result a - b - bin, mod 2^W.
- `borrow`  out  1: borrow-out; 1 when a < b + bin (unsigned).
- `ovf`  out  1: signed overflow; present only with `SUB_SERIAL_OVF_EN`.

## Operation
- States: IDLE, RUN.
- IDLE with `start` = 1:
  - Capture a, b, bin into shift registers.
  - Clear the bit counter.
  - Go to RUN; `busy` <= 1.
- RUN, each cycle, bit i = counter value:
  - d = a[i] ^ b[i] ^ br.
  - br_next = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br).
  - br starts at the captured bin.
  - d is shifted into an internal partial register, filled from the MSB and shifted right.
- When the counter reaches W-1, the final bit is computed. On that edge:
  - `diff` <= completed partial word, `borrow` <= br_next, `done` <= 1, `busy` <= 0.
  - Return to IDLE.
- `diff`/`borrow` (and `ovf`) are output registers updated only at completion. They hold the last result until the next completion; partial results are never visible.
- `start` while `busy` = 1 is ignored; captured operands are unaffected.
- `start` in the cycle where `done` = 1 is accepted (busy is already 0), giving back-to-back operation with no idle cycle.
- Operand inputs are don't-care except in the accept cycle.

## Timing
- Reset: `rst` = 1 at a rising edge forces IDLE. Every output becomes 0: `busy`, `done`, `diff`, `borrow`, `ovf`. Counter and shift registers are cleared.
- Reset mid-operation aborts it: no `done`, and the previous result is lost (outputs read 0).
- `rst` has priority over `start` in the same cycle.
- Latency: `start` accepted at edge T. `busy` is high from after T until edge T+W. `done` is high for exactly the cycle following edge T+W, i.e. W cycles after acceptance.
- Throughput: one result per W cycles.
- `done` never stays high for more than one cycle.

## Configuration
- `SUB_SERIAL_OVF_EN` defined:
  - Adds the `ovf` output.
  - At completion, `ovf` <= (a[W-1] ^ b[W-1]) & (a[W-1] ^ diff[W-1]), using the captured a and b.
  - Reset value 0.
  - Updated only at completion, like `diff`.
- `SUB_SERIAL_OVF_EN` undefined: the `ovf` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with `start` = 1 -> `busy` = `done` = `diff` = `borrow` = 0 and no operation starts.
- a=100, b=37, bin=0 -> `diff` = 63, `borrow` = 0. `done` high exactly 8 cycles after acceptance, for 1 cycle.
- a=0, b=1, bin=0 -> `diff` = 255, `borrow` = 1. Also a=0, b=0, bin=1 -> 255/1, and a=200, b=200, bin=0 -> 0/0.
- Start handling:
  - Pulse `start` with a=5, b=9 at cycle 3 of a running 50-10 operation -> ignored; result 40/0.
  - Then `start` with 7-7 in the `done` cycle -> accepted; `done` 8 cycles later with 0/0.
- Assert `rst` at cycle 4 of 250-3 -> no `done` pulse, outputs 0, block in IDLE; the next `start` completes normally.
- With `SUB_SERIAL_OVF_EN`: a=128, b=1, bin=0 -> `diff` = 127, `ovf` = 1. a=10, b=3 -> `ovf` = 0.
- Random check: 16 random {a, b, bin} -> {borrow, diff} == (a - b - bin) mod 2^(W+1). The bench logs a pass count.
